uart_rx_framer: RTL and testbench



---
 rtl/uart_frame_pkg.sv | 22 ++
 rtl/uart_frame_buf.sv | 32 +++
 rtl/uart_rx_framer.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_rx_framer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART packet framer.
//   frame_state_t : framer FSM states
//   SOF_DEFAULT   : default start-of-frame byte
//   csum8         : one step of the mod-256 running checksum
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CSUM    = 3'd3,
        DRAIN   = 3'd4
    } frame_state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    // Adds one byte to the running sum; the 8-bit result wraps mod 256.
    function automatic logic [7:0] csum8(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register file, one synchronous write port and
// one combinational read port. Storage is not reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
module uart_frame_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    // Storage write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_framer.sv
// Packet framer: parses SOF, LEN, payload, CSUM from the UART receiver byte
// stream, buffers the payload and releases it on a valid/ready stream only
// when the checksum verifies. Errors are reported as one-cycle pulses.
//   clk, reset              : clock, asynchronous active-high reset
//   rx_done_tick, rx_data   : received byte strobe and data
//   s_tick                  : baud oversampling tick (timeout time base)
//   pl_data/pl_valid/pl_last/pl_ready : payload output stream
//   frame_ok                : frame verified pulse
//   err_csum/err_len/err_timeout/overrun : error pulses
module uart_rx_framer
    import uart_frame_pkg::*;
#(
    parameter int unsigned MAX_LEN       = 16,
    parameter int unsigned TIMEOUT_TICKS = 1024,
    parameter logic [7:0]  SOF           = SOF_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       s_tick,
    output logic [7:0] pl_data,
    output logic       pl_valid,
    output logic       pl_last,
    input  logic       pl_ready,
    output logic       frame_ok,
    output logic       err_csum,
    output logic       err_len,
    output logic       err_timeout,
    output logic       overrun
);

    localparam int unsigned AW = $clog2(MAX_LEN);
    localparam int unsigned TW = $clog2(TIMEOUT_TICKS);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_TICKS - 1);

    frame_state_t  state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    wr_idx_q, wr_idx_d;
    logic [7:0]    rd_idx_q, rd_idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    pl_data_q, pl_data_d;
    logic          pl_valid_q, pl_valid_d;
    logic          pl_last_q, pl_last_d;
    logic          frame_ok_q, frame_ok_d;
    logic          err_csum_q, err_csum_d;
    logic          err_len_q, err_len_d;
    logic          err_timeout_q, err_timeout_d;
    logic          overrun_q, overrun_d;

    logic          timed_s;
    logic          timeout_s;
    logic          buf_we_s;
    logic [AW-1:0] buf_raddr_s;
    logic [7:0]    buf_rdata_s;
    logic [7:0]    wr_next_s;
    logic [7:0]    rd_next_s;

    assign wr_next_s = wr_idx_q + 8'd1;
    assign rd_next_s = rd_idx_q + 8'd1;
    assign timed_s   = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CSUM);
    // A byte arriving on the final tick wins over the timeout.
    assign timeout_s = timed_s && s_tick && !rx_done_tick && (tcnt_q == TO_LAST);

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk_i   (clk),
        .we_i    (buf_we_s),
        .waddr_i (wr_idx_q[AW-1:0]),
        .wdata_i (rx_data),
        .raddr_i (buf_raddr_s),
        .rdata_o (buf_rdata_s)
    );

    // Next-state, datapath and output-register computation.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        sum_d         = sum_q;
        pl_data_d     = pl_data_q;
        pl_valid_d    = pl_valid_q;
        pl_last_d     = pl_last_q;
        frame_ok_d    = 1'b0;
        err_csum_d    = 1'b0;
        err_len_d     = 1'b0;
        err_timeout_d = 1'b0;
        overrun_d     = 1'b0;
        buf_we_s      = 1'b0;

        // The first byte is prefetched while the checksum is checked;
        // during the drain the read port looks one byte ahead.
        if (state_q == DRAIN) begin
            buf_raddr_s = rd_next_s[AW-1:0];
        end else begin
            buf_raddr_s = {AW{1'b0}};
        end

        if (rx_done_tick || !timed_s) begin
            tcnt_d = {TW{1'b0}};
        end else if (s_tick) begin
            tcnt_d = (tcnt_q == TO_LAST) ? {TW{1'b0}} : tcnt_q + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            tcnt_d = tcnt_q;
        end

        case (state_q)
            IDLE: begin
                if (rx_done_tick && (rx_data == SOF)) begin
                    state_d = LEN;
                    sum_d   = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            LEN: begin
                if (rx_done_tick) begin
                    len_d    = rx_data;
                    sum_d    = csum8(sum_q, rx_data);
                    wr_idx_d = 8'd0;
                    if (rx_data > MAX_LEN_B) begin
                        err_len_d = 1'b1;
                        state_d   = IDLE;
                    end else if (rx_data == 8'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end else if (timeout_s) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    state_d = LEN;
                end
            end
            PAYLOAD: begin
                if (rx_done_tick) begin
                    buf_we_s = 1'b1;
                    sum_d    = csum8(sum_q, rx_data);
                    wr_idx_d = wr_next_s;
                    if (wr_next_s == len_q) begin
                        state_d = CSUM;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end else if (timeout_s) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    state_d = PAYLOAD;
                end
            end
            CSUM: begin
                if (rx_done_tick) begin
                    if (csum8(sum_q, rx_data) == 8'd0) begin
                        frame_ok_d = 1'b1;
                        if (len_q != 8'd0) begin
                            state_d    = DRAIN;
                            rd_idx_d   = 8'd0;
                            pl_valid_d = 1'b1;
                            pl_data_d  = buf_rdata_s;
                            pl_last_d  = (len_q == 8'd1);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        err_csum_d = 1'b1;
                        state_d    = IDLE;
                    end
                end else if (timeout_s) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    state_d = CSUM;
                end
            end
            DRAIN: begin
                // Bytes arriving now cannot be buffered; flag and drop them.
                overrun_d = rx_done_tick;
                if (pl_valid_q && pl_ready) begin
                    if (pl_last_q) begin
                        pl_valid_d = 1'b0;
                        pl_last_d  = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        rd_idx_d  = rd_next_s;
                        pl_data_d = buf_rdata_s;
                        pl_last_d = (rd_next_s == (len_q - 8'd1));
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d    = IDLE;
                pl_valid_d = 1'b0;
                pl_last_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            len_q         <= 8'd0;
            wr_idx_q      <= 8'd0;
            rd_idx_q      <= 8'd0;
            sum_q         <= 8'd0;
            tcnt_q        <= {TW{1'b0}};
            pl_data_q     <= 8'h00;
            pl_valid_q    <= 1'b0;
            pl_last_q     <= 1'b0;
            frame_ok_q    <= 1'b0;
            err_csum_q    <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            sum_q         <= sum_d;
            tcnt_q        <= tcnt_d;
            pl_data_q     <= pl_data_d;
            pl_valid_q    <= pl_valid_d;
            pl_last_q     <= pl_last_d;
            frame_ok_q    <= frame_ok_d;
            err_csum_q    <= err_csum_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
            overrun_q     <= overrun_d;
        end
    end

    assign pl_data     = pl_data_q;
    assign pl_valid    = pl_valid_q;
    assign pl_last     = pl_last_q;
    assign frame_ok    = frame_ok_q;
    assign err_csum    = err_csum_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_timeout_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard testbench for uart_rx_framer: directed frames from the test
// plan followed by randomized frames, checked against a frame-level model.
module tb_uart_rx_framer;

    localparam int MAX_LEN       = 16;
    localparam int TIMEOUT_TICKS = 1024;
    localparam logic [7:0] SOF_B = 8'hA5;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       s_tick;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_last;
    logic       pl_ready;
    logic       frame_ok;
    logic       err_csum;
    logic       err_len;
    logic       err_timeout;
    logic       overrun;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t      exp_pl[$];
    int         exp_ok   = 0;
    int         exp_csum = 0;
    int         exp_len  = 0;
    int         exp_to   = 0;
    int         exp_ovr  = 0;
    logic [7:0] fr_pl[$];

    bit   ready_mode  = 1'b1;
    logic ready_force = 1'b1;

    uart_rx_framer #(
        .MAX_LEN       (MAX_LEN),
        .TIMEOUT_TICKS (TIMEOUT_TICKS),
        .SOF           (SOF_B)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .s_tick       (s_tick),
        .pl_data      (pl_data),
        .pl_valid     (pl_valid),
        .pl_last      (pl_last),
        .pl_ready     (pl_ready),
        .frame_ok     (frame_ok),
        .err_csum     (err_csum),
        .err_len      (err_len),
        .err_timeout  (err_timeout),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Consumer: forced ready level or random backpressure.
    always @(posedge clk) begin
        #2;
        pl_ready = ready_mode ? ready_force : ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic take(input string name, inout int cnt);
        tests++;
        if (cnt == 0) begin
            fails++;
            $display("FAIL %s: unexpected pulse at %0t", name, $time);
        end else begin
            cnt--;
        end
    endtask

    function automatic int outstanding();
        return exp_pl.size() + exp_ok + exp_csum + exp_len + exp_to + exp_ovr;
    endfunction

    // Monitor: pops expectations whenever the DUT presents an event.
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_last  = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge clk) begin
        beat_t b;
        if (reset) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (pl_valid && !prev_valid) check("valid_rises_with_frame_ok", frame_ok, 1);
            if (prev_valid && !prev_ready) begin
                check("stall_valid_held", pl_valid, 1);
                check("stall_data_held", pl_data, prev_data);
                check("stall_last_held", pl_last, prev_last);
            end
            if (prev_valid && prev_ready && prev_last) check("valid_drops_after_last", pl_valid, 0);
            if (frame_ok)    take("frame_ok", exp_ok);
            if (err_csum)    take("err_csum", exp_csum);
            if (err_len)     take("err_len", exp_len);
            if (err_timeout) take("err_timeout", exp_to);
            if (overrun)     take("overrun", exp_ovr);
            if (pl_valid && pl_ready) begin
                if (exp_pl.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL pl_beat: unexpected byte %0h at %0t", pl_data, $time);
                end else begin
                    b = exp_pl.pop_front();
                    check("pl_data", pl_data, b.data);
                    check("pl_last", pl_last, b.last);
                end
            end
            prev_valid = pl_valid;
            prev_ready = pl_ready;
            prev_last  = pl_last;
            prev_data  = pl_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One byte strobe, then `gap` idle cycles with random baud ticks.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_done_tick = 1'b1;
        rx_data      = b;
        s_tick       = 1'b0;
        step();
        rx_done_tick = 1'b0;
        for (int i = 0; i < gap; i++) begin
            s_tick = 1'($urandom_range(0, 1));
            step();
        end
        s_tick = 1'b0;
    endtask

    // Reference model: frame outcome from the length rule and checksum
    // arithmetic; expectations are queued before the deciding byte is sent.
    task automatic send_frame(input logic [7:0] len, input bit corrupt, input int maxgap);
        int         s;
        logic [7:0] cs;
        s = int'(len);
        foreach (fr_pl[i]) s += int'(fr_pl[i]);
        cs = 8'((256 - (s % 256)) % 256);
        if (corrupt) cs = cs + 8'($urandom_range(1, 255));
        send_byte(SOF_B, $urandom_range(0, maxgap));
        if (int'(len) > MAX_LEN) begin
            exp_len++;
            send_byte(len, 0);
            return;
        end
        send_byte(len, $urandom_range(0, maxgap));
        foreach (fr_pl[i]) send_byte(fr_pl[i], $urandom_range(0, maxgap));
        if (corrupt) begin
            exp_csum++;
        end else begin
            exp_ok++;
            foreach (fr_pl[i]) exp_pl.push_back('{data: fr_pl[i], last: (i == int'(len) - 1)});
        end
        send_byte(cs, 0);
    endtask

    task automatic settle();
        int n = 0;
        while (outstanding() != 0 && n < 2000) begin
            step();
            n++;
        end
        check("scoreboard_drained", outstanding(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pl_valid"}, pl_valid, 0);
        check({tag, "_pl_last"}, pl_last, 0);
        check({tag, "_pl_data"}, pl_data, 0);
        check({tag, "_frame_ok"}, frame_ok, 0);
        check({tag, "_errors"}, {err_csum, err_len, err_timeout, overrun}, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        s_tick       = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        // Good frame with pl_ready held high.
        ready_mode = 1'b1;
        ready_force = 1'b1;
        fr_pl = '{8'h11, 8'h22, 8'h33};
        send_frame(8'd3, 1'b0, 0);
        check("good_frame_ok", frame_ok, 1);
        check("good_first_byte", pl_data, 8'h11);
        settle();

        // Bad checksum: A5 03 11 22 33 98.
        send_byte(SOF_B, 0);
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        exp_csum++;
        send_byte(8'h98, 0);
        check("bad_csum_pulse", err_csum, 1);
        check("bad_csum_no_valid", pl_valid, 0);
        settle();
        send_frame(8'd3, 1'b0, 1);
        settle();

        // Length violation, then an empty frame.
        send_byte(SOF_B, 0);
        exp_len++;
        send_byte(8'h11, 0);
        check("len_pulse", err_len, 1);
        settle();
        fr_pl.delete();
        send_frame(8'd0, 1'b0, 0);
        check("empty_frame_ok", frame_ok, 1);
        check("empty_frame_no_valid", pl_valid, 0);
        settle();

        // Timeout after A5 02 44.
        send_byte(SOF_B, 0);
        send_byte(8'h02, 0);
        send_byte(8'h44, 0);
        exp_to++;
        s_tick = 1'b1;
        repeat (TIMEOUT_TICKS - 1) step();
        check("timeout_not_early", err_timeout, 0);
        step();
        s_tick = 1'b0;
        check("timeout_pulse", err_timeout, 1);
        step();
        check("timeout_once", err_timeout, 0);
        settle();
        fr_pl = '{8'h5A};
        send_frame(8'd1, 1'b0, 0);
        settle();

        // Byte on the final tick suppresses the timeout.
        send_byte(SOF_B, 0);
        send_byte(8'h02, 0);
        send_byte(8'h44, 0);
        s_tick = 1'b1;
        repeat (TIMEOUT_TICKS - 1) step();
        rx_done_tick = 1'b1;
        rx_data      = 8'h55;
        step();
        rx_done_tick = 1'b0;
        s_tick       = 1'b0;
        check("timeout_suppressed", err_timeout, 0);
        exp_ok++;
        exp_pl.push_back('{data: 8'h44, last: 1'b0});
        exp_pl.push_back('{data: 8'h55, last: 1'b1});
        send_byte(8'h65, 0);
        settle();

        // Backpressure 1,0,0,1 with a byte injected during the drain.
        fr_pl = '{8'h11, 8'h22, 8'h33};
        send_frame(8'd3, 1'b0, 0);
        ready_force = 1'b1;
        step();
        ready_force = 1'b0;
        exp_ovr++;
        rx_done_tick = 1'b1;
        rx_data      = 8'($urandom);
        step();
        rx_done_tick = 1'b0;
        check("overrun_pulse", overrun, 1);
        check("stalled_data", pl_data, 8'h22);
        ready_force = 1'b1;
        settle();

        // Reset asserted mid-payload.
        send_byte(SOF_B, 0);
        send_byte(8'h05, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        step();
        reset = 1'b0;
        step();
        fr_pl = '{8'h7F};
        send_frame(8'd1, 1'b0, 0);
        check("post_reset_ok", frame_ok, 1);
        check("post_reset_last", pl_last, 1);
        settle();

        // Randomized frames with random backpressure and byte gaps.
        ready_mode = 1'b0;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 9) == 0) len = $urandom_range(MAX_LEN + 1, 255);
            else len = $urandom_range(0, MAX_LEN);
            fr_pl.delete();
            if (len <= MAX_LEN) begin
                for (int i = 0; i < len; i++) fr_pl.push_back(8'($urandom));
            end
            send_frame(8'(len), ($urandom_range(0, 4) == 0), 3);
            settle();
        end

        repeat (4) step();
        check("final_outstanding", outstanding(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
